// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: instruction bundle,
// funct3 encodings, FSM states and the alignment rule.
package mem_access_pkg;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        logic [2:0] funct3;
    } instr_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        DONE
    } state_e;

    // Unsigned variants exist only for loads; unknown encodings are faults.
    function automatic logic is_misaligned(
        input logic       store,
        input logic [2:0] f3,
        input logic [1:0] a
    );
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = a[0];
            F3_W:    bad = |a;
            F3_BU:   bad = store;
            F3_HU:   bad = store | a[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Selects and extends the addressed byte/half/word from the read data.
module load_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  a,
    input  logic [31:0] rdata,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[8*a +: 8];
        half_sel = a[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    value = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   value = {24'd0, byte_sel};
            F3_H:    value = {{16{half_sel[15]}}, half_sel};
            F3_HU:   value = {16'd0, half_sel};
            F3_W:    value = rdata;
            default: value = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: issues one bus transaction per load/store and
// returns the aligned/extended load value or passes the ALU result through.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enabled,
    output logic              completed,
    input  instr_t            instr,
    input  logic [31:0]       result,
    input  logic [31:0]       store_data,
    output instr_t            instr_out,
    output logic [31:0]       data_out,
    output logic              fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
);

    state_e            state_q, state_d;
    instr_t            instr_q, instr_d;
    logic [1:0]        a_q, a_d;
    logic              completed_q, completed_d;
    logic              fault_q, fault_d;
    logic [31:0]       data_out_q, data_out_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;

    logic [31:0] load_val;
    logic [31:0] word_addr;
    logic        mis;

    load_align u_load_align (
        .funct3 (instr_q.funct3),
        .a      (a_q),
        .rdata  (mem_rdata),
        .value  (load_val)
    );

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        a_d         = a_q;
        completed_d = completed_q;
        fault_d     = fault_q;
        data_out_d  = data_out_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        word_addr   = {result[31:2], 2'b00};
        mis = is_misaligned(instr.is_store, instr.funct3, result[1:0]);

        case (state_q)
            IDLE: begin
                if (enabled) begin
                    instr_d     = instr;
                    a_d         = result[1:0];
                    data_out_d  = 32'd0;
                    fault_d     = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'd0;
                    mem_wdata_d = 32'd0;
                    if (!instr.is_load && !instr.is_store) begin
                        state_d     = DONE;
                        completed_d = 1'b1;
                        data_out_d  = result;
                    end else if (mis) begin
                        state_d     = DONE;
                        completed_d = 1'b1;
                        fault_d     = 1'b1;
                    end else begin
                        state_d    = WAIT_ACK;
                        mem_req_d  = 1'b1;
                        mem_we_d   = instr.is_store;
                        mem_addr_d = ADDR_W'(word_addr);
                        if (instr.is_store) begin
                            case (instr.funct3)
                                F3_B: begin
                                    mem_wstrb_d = 4'b0001 << result[1:0];
                                    mem_wdata_d = {4{store_data[7:0]}};
                                end
                                F3_H: begin
                                    mem_wstrb_d = 4'b0011 << result[1:0];
                                    mem_wdata_d = {2{store_data[15:0]}};
                                end
                                default: begin
                                    mem_wstrb_d = 4'b1111;
                                    mem_wdata_d = store_data;
                                end
                            endcase
                        end
                    end
                end
            end
            WAIT_ACK: begin
                if (mem_ack) begin
                    state_d     = DONE;
                    completed_d = 1'b1;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = 4'd0;
                    data_out_d  = instr_q.is_store ? 32'd0 : load_val;
                end
            end
            DONE: begin
                state_d     = IDLE;
                completed_d = 1'b0;
                fault_d     = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            instr_q     <= '0;
            a_q         <= 2'd0;
            completed_q <= 1'b0;
            fault_q     <= 1'b0;
            data_out_q  <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            mem_wstrb_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            a_q         <= a_d;
            completed_q <= completed_d;
            fault_q     <= fault_d;
            data_out_q  <= data_out_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign completed = completed_q;
    assign fault     = fault_q;
    assign data_out  = data_out_q;
    assign instr_out = instr_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed and randomized checks of mem_access against a behavioural
// model of the load/store rules.
module tb_mem_access;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enabled;
    logic        completed;
    instr_t      instr;
    logic [31:0] result;
    logic [31:0] store_data;
    instr_t      instr_out;
    logic [31:0] data_out;
    logic        fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enabled    (enabled),
        .completed  (completed),
        .instr      (instr),
        .result     (result),
        .store_data (store_data),
        .instr_out  (instr_out),
        .data_out   (data_out),
        .fault      (fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input logic l, input logic s,
                                  input logic [2:0] f3);
        instr_t i;
        i.is_load  = l;
        i.is_store = s;
        i.funct3   = f3;
        return i;
    endfunction

    // Access size in bytes is 2**funct3[1:0]; only listed encodings are legal.
    function automatic logic ref_mis(input logic st, input logic [2:0] f3,
                                     input logic [31:0] addr);
        int  sz;
        logic ok;
        ok = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz = 1 << f3[1:0];
        return !ok || ((addr % sz) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                             input logic [31:0] addr,
                                             input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * (addr % 4))) & 32'hFF;
        h = (rd >> (16 * ((addr % 4) / 2))) & 32'hFFFF;
        case (f3)
            3'd0: return (b >= 32'h80) ? b - 32'h100 : b;
            3'd4: return b;
            3'd1: return (h >= 32'h8000) ? h - 32'h10000 : h;
            3'd5: return h;
            default: return rd;
        endcase
    endfunction

    task automatic txn(input instr_t i, input logic [31:0] res,
                       input logic [31:0] sd, input logic [31:0] rd,
                       input int d);
        logic        is_mem;
        logic        mis;
        int          sz;
        logic [3:0]  strb;
        logic [31:0] wd;
        is_mem = i.is_load | i.is_store;
        mis = is_mem && ref_mis(i.is_store, i.funct3, res);
        @(negedge clk);
        enabled    = 1'b1;
        instr      = i;
        result     = res;
        store_data = sd;
        @(negedge clk);
        enabled = 1'b0;
        instr   = instr_t'(5'($urandom));
        result  = $urandom;
        chk("instr_out", 32'(instr_out), 32'(i));
        if (!is_mem || mis) begin
            chk("quick_completed", 32'(completed), 32'd1);
            chk("quick_fault", 32'(fault), 32'(mis));
            chk("quick_data", data_out, mis ? 32'd0 : res);
            chk("quick_no_req", 32'(mem_req), 32'd0);
        end else begin
            sz   = 1 << i.funct3[1:0];
            strb = 4'(((1 << sz) - 1) << (res % 4));
            wd   = (sz == 1) ? {4{sd[7:0]}} :
                   (sz == 2) ? {2{sd[15:0]}} : sd;
            chk("req", 32'(mem_req), 32'd1);
            chk("req_completed", 32'(completed), 32'd0);
            chk("we", 32'(mem_we), 32'(i.is_store));
            chk("addr", mem_addr, res & ~32'd3);
            if (i.is_store) begin
                chk("wstrb", 32'(mem_wstrb), 32'(strb));
                chk("wdata", mem_wdata, wd);
            end
            for (int k = 0; k < d; k++) begin
                enabled = 1'($urandom);
                instr   = instr_t'(5'($urandom));
                @(negedge clk);
                chk("hold_req", 32'(mem_req), 32'd1);
                chk("hold_addr", mem_addr, res & ~32'd3);
                chk("hold_completed", 32'(completed), 32'd0);
            end
            enabled   = 1'b0;
            mem_ack   = 1'b1;
            mem_rdata = rd;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            chk("ack_completed", 32'(completed), 32'd1);
            chk("ack_fault", 32'(fault), 32'd0);
            chk("ack_req_drop", 32'(mem_req), 32'd0);
            chk("ack_data", data_out,
                i.is_store ? 32'd0 : ref_load(i.funct3, res, rd));
        end
        @(negedge clk);
        chk("pulse_end", 32'(completed), 32'd0);
        chk("idle_no_req", 32'(mem_req), 32'd0);
        chk("instr_held", 32'(instr_out), 32'(i));
    endtask

    initial begin
        logic [31:0] held;
        instr_t      ri;
        int          kind;
        rstn       = 1'b0;
        enabled    = 1'b0;
        instr      = '0;
        result     = 32'd0;
        store_data = 32'd0;
        mem_rdata  = 32'd0;
        mem_ack    = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_completed", 32'(completed), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_data", data_out, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rstn = 1'b1;

        txn(mk(1'b0, 1'b0, 3'd0), 32'h1234, 32'd0, 32'd0, 0);
        txn(mk(1'b1, 1'b0, F3_B), 32'h101, 32'd0, 32'h0080FF00, 3);
        chk("lb_value", data_out, 32'hFFFFFFFF);
        txn(mk(1'b1, 1'b0, F3_HU), 32'h202, 32'd0, 32'h80010000, 1);
        chk("lhu_value", data_out, 32'h00008001);
        txn(mk(1'b0, 1'b1, F3_B), 32'h303, 32'hAB, 32'd0, 2);
        txn(mk(1'b1, 1'b0, F3_W), 32'h402, 32'd0, 32'd0, 0);
        chk("lw_mis_fault_gone", 32'(fault), 32'd0);
        txn(mk(1'b0, 1'b1, F3_H), 32'h612, 32'hCAFE1234, 32'd0, 0);
        txn(mk(1'b0, 1'b1, F3_W), 32'h700, 32'h89ABCDEF, 32'd0, 1);
        txn(mk(1'b1, 1'b0, 3'd3), 32'h800, 32'd0, 32'd0, 0);

        held = data_out;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_ack_completed", 32'(completed), 32'd0);
        chk("idle_ack_data", data_out, held);

        @(negedge clk);
        enabled = 1'b1;
        instr   = mk(1'b1, 1'b0, F3_W);
        result  = 32'h500;
        @(negedge clk);
        enabled = 1'b0;
        chk("rstwait_req", 32'(mem_req), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        chk("rstwait_req_drop", 32'(mem_req), 32'd0);
        chk("rstwait_completed", 32'(completed), 32'd0);
        rstn      = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late_ack_completed", 32'(completed), 32'd0);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        chk("late_ack_completed2", 32'(completed), 32'd0);
        txn(mk(1'b0, 1'b0, 3'd7), 32'hDEADBEEF, 32'd0, 32'd0, 0);

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            ri = mk(kind == 1, kind == 2, 3'($urandom_range(0, 7)));
            txn(ri, $urandom, $urandom, $urandom, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
